// File: rtl/reg_bus_if.sv
// Register-bus arbiter signal bundle: two requesting masters and one shared
// register port.
//
// Handshake: a master raises mN_req with we/addr/wdata/wstrb stable and keeps it
// high until it sees mN_done.  mN_done is a one-cycle pulse.  rdata and err are
// valid from that pulse onward.  The master drops req in its done cycle.  The
// shared port is strobe based: t_wen or t_ren is high for one cycle.  During that
// cycle the register file answers combinationally on t_rdata / t_error.
interface reg_bus_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                      m0_req;
    logic                      m0_we;
    logic [REG_ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0]     m0_wdata;
    logic [STRB_WIDTH-1:0]     m0_wstrb;
    logic                      m0_done;
    logic [DATA_WIDTH-1:0]     m0_rdata;
    logic                      m0_err;

    logic                      m1_req;
    logic                      m1_we;
    logic [REG_ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0]     m1_wdata;
    logic [STRB_WIDTH-1:0]     m1_wstrb;
    logic                      m1_done;
    logic [DATA_WIDTH-1:0]     m1_rdata;
    logic                      m1_err;

    logic [REG_ADDR_WIDTH-1:0] t_addr;
    logic [DATA_WIDTH-1:0]     t_wdata;
    logic [STRB_WIDTH-1:0]     t_wstrb;
    logic                      t_wen;
    logic                      t_ren;
    logic [DATA_WIDTH-1:0]     t_rdata;
    logic                      t_error;

    // Arbiter side.
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        output m0_done, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        output m1_done, m1_rdata, m1_err,
        output t_addr, t_wdata, t_wstrb, t_wen, t_ren,
        input  t_rdata, t_error
    );

    // Environment side: the masters plus the register file.
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        input  m0_done, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        input  m1_done, m1_rdata, m1_err,
        input  t_addr, t_wdata, t_wstrb, t_wen, t_ren,
        output t_rdata, t_error
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Two-master round-robin arbiter onto a single-cycle register port.
// Each access runs IDLE -> ACCESS -> DONE, so peak throughput is one access
// every three cycles.
module reg_bus_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    reg_bus_if.slave   bus,
    output logic [1:0] dbg_state
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]                state;
    logic [1:0]                state_nxt;
    logic                      last_gnt;   // port granted most recently
    logic                      cur;        // port owning the current access
    logic                      lat_we;
    logic [REG_ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]     lat_wdata;
    logic [STRB_WIDTH-1:0]     lat_wstrb;
    logic [DATA_WIDTH-1:0]     rdata0_q;
    logic [DATA_WIDTH-1:0]     rdata1_q;
    logic                      err0_q;
    logic                      err1_q;
    logic                      any_req;
    logic                      pick1;

    // Winner selection: a lone requester wins; on a tie, the port not granted last wins.
    always_comb begin
        any_req = bus.m0_req | bus.m1_req;
        pick1   = bus.m1_req & (~bus.m0_req | ~last_gnt);
    end

    // Next-state logic: exactly one step per cycle, and IDLE waits for a request.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Take a grant in IDLE: remember the owner and latch its request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt  <= 1'b1;
            cur       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
        end else if (state == IDLE && any_req) begin
            last_gnt  <= pick1;
            cur       <= pick1;
            lat_we    <= pick1 ? bus.m1_we    : bus.m0_we;
            lat_addr  <= pick1 ? bus.m1_addr  : bus.m0_addr;
            lat_wdata <= pick1 ? bus.m1_wdata : bus.m0_wdata;
            lat_wstrb <= pick1 ? bus.m1_wstrb : bus.m0_wstrb;
        end
    end

    // Capture the register-file response at the end of ACCESS.
    // Read data is captured only on reads; the error flag is captured on every access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else if (state == ACCESS) begin
            if (cur) begin
                err1_q <= bus.t_error;
                if (!lat_we) rdata1_q <= bus.t_rdata;
            end else begin
                err0_q <= bus.t_error;
                if (!lat_we) rdata0_q <= bus.t_rdata;
            end
        end
    end

    // Outputs: the strobes and done are decoded from state.
    // Because of that, an asynchronous reset drops them at once.
    always_comb begin
        bus.t_addr   = lat_addr;
        bus.t_wdata  = lat_wdata;
        bus.t_wstrb  = lat_wstrb;
        bus.t_wen    = (state == ACCESS) &  lat_we;
        bus.t_ren    = (state == ACCESS) & ~lat_we;
        bus.m0_done  = (state == DONE) & ~cur;
        bus.m1_done  = (state == DONE) &  cur;
        bus.m0_rdata = rdata0_q;
        bus.m1_rdata = rdata1_q;
        bus.m0_err   = err0_q;
        bus.m1_err   = err1_q;
        dbg_state    = state;
    end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: single accesses, tie-breaking, alternation,
// read-data retention, and reset in mid-access.
module tb_reg_bus_arbiter;
    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         tests;
    int         fails;

    reg_bus_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) bus ();

    reg_bus_arbiter #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_wstrb = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_wstrb = 0;
        bus.t_rdata = 0; bus.t_error = 0;

        // Reset state.
        tick(); tick();
        check("rst_state", 32'(dbg_state), 0);
        check("rst_t_wen", 32'(bus.t_wen), 0);
        check("rst_t_ren", 32'(bus.t_ren), 0);
        check("rst_m0_done", 32'(bus.m0_done), 0);
        check("rst_m1_done", 32'(bus.m1_done), 0);
        check("rst_t_addr", 32'(bus.t_addr), 0);
        check("rst_m0_rdata", bus.m0_rdata, 0);
        rst_n = 1'b1;
        tick();

        // m0 write: addr 3, data DEADBEEF, strobe F.
        bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 4'd3;
        bus.m0_wdata = 32'hDEADBEEF; bus.m0_wstrb = 4'hF;
        tick();
        check("wr_state_access", 32'(dbg_state), 1);
        check("wr_t_wen", 32'(bus.t_wen), 1);
        check("wr_t_ren", 32'(bus.t_ren), 0);
        check("wr_t_addr", 32'(bus.t_addr), 3);
        check("wr_t_wdata", bus.t_wdata, 32'hDEADBEEF);
        check("wr_t_wstrb", 32'(bus.t_wstrb), 32'hF);
        check("wr_no_early_done", 32'(bus.m0_done), 0);
        tick();
        check("wr_t_wen_one_cycle", 32'(bus.t_wen), 0);
        check("wr_m0_done", 32'(bus.m0_done), 1);
        check("wr_m1_done_quiet", 32'(bus.m1_done), 0);
        check("wr_m0_err", 32'(bus.m0_err), 0);
        bus.m0_req = 0;
        tick();
        check("wr_done_pulse", 32'(bus.m0_done), 0);
        check("wr_back_idle", 32'(dbg_state), 0);

        // m1 read: addr 5, the register file returns 12345678 with an error.
        bus.t_rdata = 32'h12345678; bus.t_error = 1;
        bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 4'd5;
        tick();
        check("rd_t_ren", 32'(bus.t_ren), 1);
        check("rd_t_wen", 32'(bus.t_wen), 0);
        check("rd_t_addr", 32'(bus.t_addr), 5);
        tick();
        check("rd_m1_done", 32'(bus.m1_done), 1);
        check("rd_m0_done_quiet", 32'(bus.m0_done), 0);
        check("rd_m1_rdata", bus.m1_rdata, 32'h12345678);
        check("rd_m1_err", 32'(bus.m1_err), 1);
        check("rd_t_ren_off", 32'(bus.t_ren), 0);
        bus.m1_req = 0;
        bus.t_error = 0;
        tick();
        check("rd_t_addr_hold", 32'(bus.t_addr), 5);

        // Tie straight after reset: m0 goes first, then m1, with done pulses three cycles apart.
        rst_n = 0;
        tick();
        rst_n = 1;
        bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 4'd1; bus.m0_wdata = 32'h11111111;
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 4'd2; bus.m1_wdata = 32'h22222222;
        tick();
        check("tie_first_addr", 32'(bus.t_addr), 1);
        check("tie_first_wdata", bus.t_wdata, 32'h11111111);
        tick();
        check("tie_m0_done", 32'(bus.m0_done), 1);
        check("tie_m1_wait", 32'(bus.m1_done), 0);
        bus.m0_req = 0;
        tick();
        check("tie_gap_m1_done", 32'(bus.m1_done), 0);
        tick();
        check("tie_second_addr", 32'(bus.t_addr), 2);
        check("tie_second_wen", 32'(bus.t_wen), 1);
        tick();
        check("tie_m1_done", 32'(bus.m1_done), 1);
        check("tie_m0_quiet", 32'(bus.m0_done), 0);
        bus.m1_req = 0;
        tick();

        // Both held for four transactions: grants alternate 0,1,0,1.
        bus.m0_req = 1; bus.m1_req = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("alt%0d_addr", k), 32'(bus.t_addr), (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            check($sformatf("alt%0d_m0_done", k), 32'(bus.m0_done), (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("alt%0d_m1_done", k), 32'(bus.m1_done), (k % 2 == 0) ? 32'd0 : 32'd1);
            tick();
        end
        bus.m0_req = 0; bus.m1_req = 0;
        tick();

        // m0 reads A5A5A5A5. A following m0 write must not disturb m0_rdata.
        bus.t_rdata = 32'hA5A5A5A5;
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 4'd7;
        tick(); tick();
        check("keep_rd_done", 32'(bus.m0_done), 1);
        check("keep_rd_data", bus.m0_rdata, 32'hA5A5A5A5);
        bus.m0_req = 0;
        tick();
        bus.t_rdata = 32'hFFFFFFFF;
        bus.m0_req = 1; bus.m0_we = 1; bus.m0_wdata = 32'h0BADF00D;
        tick(); tick();
        check("keep_wr_done", 32'(bus.m0_done), 1);
        check("keep_rdata_after_wr", bus.m0_rdata, 32'hA5A5A5A5);
        check("keep_err_after_wr", 32'(bus.m0_err), 0);
        bus.m0_req = 0;
        tick();

        // Reset during ACCESS: the strobe drops at once, no done pulse follows,
        // and the held request is then served normally.
        bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 4'd9; bus.m0_wdata = 32'hCAFEF00D;
        tick();
        check("abort_in_access", 32'(bus.t_wen), 1);
        #2 rst_n = 0;
        #1;
        check("abort_t_wen_now", 32'(bus.t_wen), 0);
        check("abort_t_ren_now", 32'(bus.t_ren), 0);
        check("abort_state_idle", 32'(dbg_state), 0);
        tick();
        check("abort_no_done", 32'(bus.m0_done), 0);
        check("abort_rdata_cleared", bus.m0_rdata, 0);
        rst_n = 1;
        tick();
        check("abort_regrant_wen", 32'(bus.t_wen), 1);
        check("abort_regrant_addr", 32'(bus.t_addr), 9);
        tick();
        check("abort_regrant_done", 32'(bus.m0_done), 1);
        bus.m0_req = 0;
        tick();
        check("abort_final_idle", 32'(dbg_state), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
